// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: bulk OUT/IN transaction sequencer behind usb_rx.
// Tracks tokens, moves DATA payload bytes into the endpoint buffer through a
// two-byte holding pipe so the trailing CRC16 never reaches the buffer, then
// commits or flushes the buffer and requests an ACK/NAK handshake.
module usb_rx_ctrl #(
    parameter int MAX_BYTES = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rx_packet,
    input  logic [7:0] rx_packet_data,
    input  logic       store_rx_packet_data,
    input  logic       buf_full,
    input  logic       tx_grant,
    output logic       buf_wr,
    output logic [7:0] buf_wdata,
    output logic       buf_commit,
    output logic       buf_flush,
    output logic [6:0] rx_byte_cnt,
    output logic       tx_req,
    output logic       tx_nak,
    output logic       in_req,
    output logic       ack_rcvd,
    output logic       rx_err
);

    localparam logic [2:0] PKT_IN   = 3'd1;
    localparam logic [2:0] PKT_OUT  = 3'd2;
    localparam logic [2:0] PKT_ACK  = 3'd3;
    localparam logic [2:0] PKT_ERR  = 3'd4;
    localparam logic [2:0] PKT_DONE = 3'd5;
    localparam logic [2:0] PKT_DATA = 3'd6;

    localparam int            TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [6:0]    MAX_CNT = 7'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TOKEN    = 3'd1,
        S_OUT_WAIT = 3'd2,
        S_DATA_RX  = 3'd3,
        S_DRAIN    = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TOK_IN  = 2'd0,
        TOK_OUT = 2'd1,
        TOK_ACK = 2'd2
    } tok_t;

    state_t        state_r, state_nx_s;
    tok_t          tok_r, tok_nx_s;
    logic [2:0]    prev_pkt_r;
    logic [TW-1:0] to_cnt_r, to_cnt_nx_s;
    logic [7:0]    hold0_r, hold0_nx_s;
    logic [7:0]    hold1_r, hold1_nx_s;
    logic [1:0]    held_r, held_nx_s;
    logic          ovf_r, ovf_nx_s;
    logic          done_s;

    logic          wr_nx_s;
    logic [7:0]    wdata_nx_s;
    logic          commit_nx_s;
    logic          flush_nx_s;
    logic [6:0]    cnt_nx_s;
    logic          tx_req_nx_s;
    logic          tx_nak_nx_s;
    logic          in_req_nx_s;
    logic          ack_nx_s;
    logic          err_nx_s;

    // End-of-packet event: first cycle that usb_rx reports DONE.
    assign done_s = (rx_packet == PKT_DONE) && (prev_pkt_r != PKT_DONE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, holding-pipe and next-output logic.
    always_comb begin
        state_nx_s  = state_r;
        tok_nx_s    = tok_r;
        to_cnt_nx_s = to_cnt_r;
        hold0_nx_s  = hold0_r;
        hold1_nx_s  = hold1_r;
        held_nx_s   = held_r;
        ovf_nx_s    = ovf_r;
        wr_nx_s     = 1'b0;
        wdata_nx_s  = buf_wdata;
        commit_nx_s = 1'b0;
        flush_nx_s  = 1'b0;
        cnt_nx_s    = rx_byte_cnt;
        tx_req_nx_s = tx_req;
        tx_nak_nx_s = tx_nak;
        in_req_nx_s = 1'b0;
        ack_nx_s    = 1'b0;
        err_nx_s    = 1'b0;

        case (state_r)
            S_IDLE: begin
                case (rx_packet)
                    PKT_IN: begin
                        tok_nx_s   = TOK_IN;
                        state_nx_s = S_TOKEN;
                    end
                    PKT_OUT: begin
                        tok_nx_s   = TOK_OUT;
                        state_nx_s = S_TOKEN;
                    end
                    PKT_ACK: begin
                        tok_nx_s   = TOK_ACK;
                        state_nx_s = S_TOKEN;
                    end
                    PKT_ERR, PKT_DATA: state_nx_s = S_DRAIN;
                    default:           state_nx_s = S_IDLE;
                endcase
            end

            S_TOKEN: begin
                if (done_s) begin
                    case (tok_r)
                        TOK_IN: begin
                            in_req_nx_s = 1'b1;
                            state_nx_s  = S_IDLE;
                        end
                        TOK_ACK: begin
                            ack_nx_s   = 1'b1;
                            state_nx_s = S_IDLE;
                        end
                        TOK_OUT: begin
                            to_cnt_nx_s = {TW{1'b0}};
                            state_nx_s  = S_OUT_WAIT;
                        end
                        default: state_nx_s = S_IDLE;
                    endcase
                end else if (rx_packet == PKT_ERR) begin
                    state_nx_s = S_DRAIN;
                end else begin
                    state_nx_s = S_TOKEN;
                end
            end

            S_OUT_WAIT: begin
                if (rx_packet == PKT_DATA) begin
                    held_nx_s  = 2'd0;
                    ovf_nx_s   = 1'b0;
                    cnt_nx_s   = 7'd0;
                    state_nx_s = S_DATA_RX;
                end else if (to_cnt_r == TO_LAST) begin
                    err_nx_s   = 1'b1;
                    state_nx_s = S_IDLE;
                end else if ((rx_packet >= PKT_IN) && (rx_packet <= PKT_ERR)) begin
                    state_nx_s = S_DRAIN;
                end else begin
                    to_cnt_nx_s = to_cnt_r + TW'(1);
                end
            end

            S_DATA_RX: begin
                // A strobe is folded in first so a byte arriving with DONE counts.
                if (store_rx_packet_data) begin
                    case (held_r)
                        2'd0: begin
                            hold0_nx_s = rx_packet_data;
                            held_nx_s  = 2'd1;
                        end
                        2'd1: begin
                            hold1_nx_s = rx_packet_data;
                            held_nx_s  = 2'd2;
                        end
                        default: begin
                            if (buf_full || (rx_byte_cnt == MAX_CNT)) begin
                                ovf_nx_s = 1'b1;
                            end else begin
                                wr_nx_s    = 1'b1;
                                wdata_nx_s = hold0_r;
                                cnt_nx_s   = rx_byte_cnt + 7'd1;
                            end
                            hold0_nx_s = hold1_r;
                            hold1_nx_s = rx_packet_data;
                        end
                    endcase
                end else begin
                    held_nx_s = held_r;
                end

                if (done_s) begin
                    if (held_nx_s != 2'd2) begin
                        // Too short to even carry a CRC16.
                        flush_nx_s = 1'b1;
                        err_nx_s   = 1'b1;
                        state_nx_s = S_IDLE;
                    end else if (ovf_nx_s) begin
                        flush_nx_s  = 1'b1;
                        tx_req_nx_s = 1'b1;
                        tx_nak_nx_s = 1'b1;
                        state_nx_s  = S_RESP;
                    end else begin
                        commit_nx_s = 1'b1;
                        tx_req_nx_s = 1'b1;
                        tx_nak_nx_s = 1'b0;
                        state_nx_s  = S_RESP;
                    end
                    held_nx_s = 2'd0;
                end else if (rx_packet == PKT_ERR) begin
                    flush_nx_s = 1'b1;
                    held_nx_s  = 2'd0;
                    state_nx_s = S_DRAIN;
                end else begin
                    state_nx_s = S_DATA_RX;
                end
            end

            S_DRAIN: begin
                if (done_s) begin
                    err_nx_s   = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DRAIN;
                end
            end

            S_RESP: begin
                if (tx_grant) begin
                    tx_req_nx_s = 1'b0;
                    tx_nak_nx_s = 1'b0;
                    state_nx_s  = S_IDLE;
                end else begin
                    state_nx_s = S_RESP;
                end
            end

            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_r       <= TOK_IN;
            prev_pkt_r  <= 3'd0;
            to_cnt_r    <= {TW{1'b0}};
            hold0_r     <= 8'd0;
            hold1_r     <= 8'd0;
            held_r      <= 2'd0;
            ovf_r       <= 1'b0;
            buf_wr      <= 1'b0;
            buf_wdata   <= 8'd0;
            buf_commit  <= 1'b0;
            buf_flush   <= 1'b0;
            rx_byte_cnt <= 7'd0;
            tx_req      <= 1'b0;
            tx_nak      <= 1'b0;
            in_req      <= 1'b0;
            ack_rcvd    <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            tok_r       <= tok_nx_s;
            prev_pkt_r  <= rx_packet;
            to_cnt_r    <= to_cnt_nx_s;
            hold0_r     <= hold0_nx_s;
            hold1_r     <= hold1_nx_s;
            held_r      <= held_nx_s;
            ovf_r       <= ovf_nx_s;
            buf_wr      <= wr_nx_s;
            buf_wdata   <= wdata_nx_s;
            buf_commit  <= commit_nx_s;
            buf_flush   <= flush_nx_s;
            rx_byte_cnt <= cnt_nx_s;
            tx_req      <= tx_req_nx_s;
            tx_nak      <= tx_nak_nx_s;
            in_req      <= in_req_nx_s;
            ack_rcvd    <= ack_nx_s;
            rx_err      <= err_nx_s;
        end
    end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Transaction-level controller that sits directly behind `usb_rx` in the bulk-endpoint RX path. It interprets the `rx_packet` status and `store_rx_packet_data` strobe stream, and sequences OUT-token/DATA payload bytes into the endpoint data buffer while stripping the 2 trailing CRC16 bytes. At end of packet it commits or flushes the buffer and requests an ACK or NAK handshake from the TX side. It also reports IN tokens, host ACKs and receive errors to the endpoint/AHB control logic.

## Interface
- `MAX_BYTES`, 64: maximum payload bytes accepted per DATA packet, excluding CRC.
- `TIMEOUT`, 1024: clk cycles allowed between end of an OUT token and start of a DATA packet.
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `rx_packet` in 3: from usb_rx. 0 NONE, 1 IN, 2 OUT, 3 ACK, 4 ERR, 5 DONE, 6 DATA (DATA0/DATA1 PID seen).
- `rx_packet_data` in 8: received byte, valid with strobe.
- `store_rx_packet_data` in 1: one-cycle byte-valid strobe.
- `buf_full` in 1: buffer cannot accept a write this cycle.
- `tx_grant` in 1: TX has accepted the handshake request.
- `buf_wr` out 1: one-cycle buffer write strobe.
- `buf_wdata` out 8: byte to write, valid with `buf_wr`.
- `buf_commit` out 1: one-cycle pulse; keep the bytes written for this packet.
- `buf_flush` out 1: one-cycle pulse; discard the bytes written for this packet.
- `rx_byte_cnt` out 7: payload bytes written for the current or last packet.
- `tx_req` out 1: handshake request, level.
- `tx_nak` out 1: with `tx_req`. 0 = ACK, 1 = NAK.
- `in_req` out 1: one-cycle pulse; valid IN token completed.
- `ack_rcvd` out 1: one-cycle pulse; host ACK packet completed.
- `rx_err` out 1: one-cycle pulse; packet or transaction aborted.

## Operation
- DONE event: cycle where `rx_packet`==5 and its registered previous value !=5. All end-of-packet actions key on this event.
- States:
  - IDLE
  - TOKEN: header bytes are ignored.
  - OUT_WAIT
  - DATA_RX
  - DRAIN: error seen, waiting for DONE.
  - RESP
- IDLE:
  - `rx_packet` 1 or 2: latch the token type, go to TOKEN.
  - 3: latch ACK, go to TOKEN.
  - 6: unsolicited DATA, go to DRAIN.
  - 4: go to DRAIN.
- TOKEN on DONE:
  - IN: pulse `in_req`, go to IDLE.
  - ACK: pulse `ack_rcvd`, go to IDLE.
  - OUT: clear the timeout counter, go to OUT_WAIT.
  - ERR in TOKEN: go to DRAIN.
- OUT_WAIT:
  - `rx_packet`==6: clear the holding pipe, `rx_byte_cnt` and the overflow flag, go to DATA_RX.
  - Counter reaches TIMEOUT-1: pulse `rx_err`, go to IDLE.
  - Any other token: go to DRAIN.
- DATA_RX: a 2-entry holding pipe strips the CRC.
  - On a strobe with fewer than 2 bytes held, the byte is pushed and nothing is written.
  - On a strobe with 2 bytes held, the oldest byte is written and the new byte is pushed.
  - A write is suppressed, and the overflow flag set, if `buf_full` is high or `rx_byte_cnt`==MAX_BYTES. The byte is still popped.
  - Each write increments `rx_byte_cnt`. It saturates at MAX_BYTES.
- DATA_RX on DONE:
  - Fewer than 2 bytes held: pulse `buf_flush` and `rx_err`, go to IDLE with no handshake.
  - Overflow flag set: pulse `buf_flush`, set `tx_nak`=1, go to RESP.
  - Otherwise: pulse `buf_commit`, set `tx_nak`=0, go to RESP.
  - The 2 held bytes are discarded.
- DATA_RX, `rx_packet`==4: pulse `buf_flush`, go to DRAIN.
- DRAIN: on DONE, pulse `rx_err`, go to IDLE.
- RESP: hold `tx_req`=1 and `tx_nak` stable until `tx_grant`. In the grant cycle drop `tx_req` and go to IDLE. Received packets are ignored in RESP.
- `tx_grant` outside RESP is ignored.
- `buf_commit` and `buf_flush` never assert in the same cycle.

## Timing
- Reset values: state IDLE; all outputs 0; `rx_byte_cnt`=0; holding pipe empty.
- `rst` mid-packet returns to IDLE next edge with no commit or flush pulse.
- Latencies:
  - `buf_wr` and `buf_wdata` are registered, 1 cycle after the strobe.
  - `in_req`, `ack_rcvd`, `buf_commit`, `buf_flush` and `rx_err` assert 1 cycle after the DONE event.
  - `tx_req` rises in the same cycle as `buf_commit`/`buf_flush`.
- `buf_full` is sampled in the strobe cycle.
- A strobe in the same cycle as the DONE event is processed before the DONE action.
- `rx_byte_cnt` holds its value after the packet until the next DATA PID.

## Test plan
- OUT token DONE, DATA PID, bytes AA AF FF E8, DONE:
  - `buf_wr` ×2 with AA then AF;
  - `buf_commit`;
  - `rx_byte_cnt`=2;
  - `tx_req`=1, `tx_nak`=0 until `tx_grant`.
- IN token then DONE: single `in_req` pulse, no `tx_req`, no `buf_wr`.
- ACK packet DONE: single `ack_rcvd`.
- OUT then DATA with 66 payload bytes + 2 CRC, MAX_BYTES=64:
  - 64 writes;
  - `buf_flush`;
  - `tx_nak`=1.
- Repeat the OUT/DATA case with `buf_full`=1 on byte 3: write suppressed, NAK on DONE.
- Error cases:
  - DATA with 1 byte then DONE: `buf_flush` + `rx_err`, no `tx_req`.
  - `rx_packet`=4 mid-DATA: flush, then `rx_err` at DONE.
  - OUT token then no DATA for TIMEOUT cycles: `rx_err`, back to IDLE.
  - `rst` asserted mid-DATA: all outputs 0 next cycle.
